// File: rtl/herald_host_bridge.sv
// herald_host_bridge
//   Byte-serial host bridge. The host writes a command byte and up to two
//   little-endian operands over an 8-bit strobe bus. The bridge then issues
//   one valid/ready request to a downstream accelerator, captures a
//   variable-length response and returns it one byte per host read. dout
//   shows a status byte whenever it is not holding a response byte.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   din, wr, rd          host write data, write strobe, read strobe (levels; rising edge acts)
//   dout                 registered read data / status {busy,rdy,err_cmd,err_tmo,err_proto,000}
//   cmd_out, cmd_nops    latched command byte and its external operand-count decode (3 = illegal)
//   req_valid/req_ready  request handshake; op_a/op_b are stable while req_valid is high
//   op_a, op_b           operands, 8*OP_BYTES bits each
//   resp_valid/ready     response handshake
//   resp_data, resp_len  response bytes (byte 0 in the LSBs) and byte count
module herald_host_bridge #(
  parameter int OP_BYTES  = 3,
  parameter int RES_BYTES = 9,
  parameter int TIMEOUT   = 1023,
  parameter int LW        = $clog2(RES_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             din,
  input  logic                   wr,
  input  logic                   rd,
  output logic [7:0]             dout,
  output logic [7:0]             cmd_out,
  input  logic [1:0]             cmd_nops,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [8*OP_BYTES-1:0]  op_a,
  output logic [8*OP_BYTES-1:0]  op_b,
  input  logic                   resp_valid,
  output logic                   resp_ready,
  input  logic [8*RES_BYTES-1:0] resp_data,
  input  logic [LW-1:0]          resp_len
);

  localparam int W  = 8 * OP_BYTES;
  localparam int BW = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
  localparam int RW = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BW-1:0] LAST_BYTE = BW'(OP_BYTES - 1);
  localparam logic [LW-1:0] MAX_LEN   = LW'(RES_BYTES);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TMO_SAT   = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_OPERAND, S_ISSUE, S_WAIT, S_RESULT
  } state_e;

  state_e                 state_q, state_d;
  logic                   wr_prev_q, rd_prev_q;
  logic [7:0]             cmd_q, cmd_d;
  logic [W-1:0]           op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0]             nops_q, nops_d;
  logic                   op_idx_q, op_idx_d;
  logic [BW-1:0]          byte_idx_q, byte_idx_d;
  logic [8*RES_BYTES-1:0] resp_q, resp_d;
  logic [LW-1:0]          len_q, len_d;
  logic [RW-1:0]          rbyte_q, rbyte_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   err_cmd_q, err_cmd_d, err_tmo_q, err_tmo_d, err_proto_q, err_proto_d;
  logic                   hold_q, hold_d;
  logic [7:0]             dout_q, dout_d;

  logic wr_e, rd_e, abort, tmo_hit, load_byte, busy_d, rdy_d;

  assign wr_e  = wr & ~wr_prev_q;
  assign rd_e  = rd & ~rd_prev_q;
  assign abort = wr_e & rd_e;

  // tmo_q counts ISSUE/WAIT cycles from 0; the TIMEOUT-th cycle is the last
  // one allowed. It saturates so that a handshake completing on that cycle
  // leaves WAIT exactly one cycle to deliver a response.
  assign tmo_hit = (TIMEOUT > 0) && (tmo_q >= TMO_LAST);

  // NOTE: every variable gets its default before the case statement, so no
  // path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    nops_d      = nops_q;
    op_idx_d    = op_idx_q;
    byte_idx_d  = byte_idx_q;
    resp_d      = resp_q;
    len_d       = len_q;
    rbyte_d     = rbyte_q;
    tmo_d       = tmo_q;
    err_cmd_d   = err_cmd_q;
    err_tmo_d   = err_tmo_q;
    err_proto_d = err_proto_q;
    hold_d      = hold_q & ~(wr_e | rd_e);
    load_byte   = 1'b0;

    if ((state_q == S_ISSUE || state_q == S_WAIT) && tmo_q != TMO_SAT)
      tmo_d = tmo_q + TW'(1);

    if (abort) begin
      // Simultaneous write and read edges reset the transaction from any state.
      state_d     = S_IDLE;
      err_cmd_d   = 1'b0;
      err_tmo_d   = 1'b0;
      err_proto_d = 1'b0;
      hold_d      = 1'b0;
      op_idx_d    = 1'b0;
      byte_idx_d  = '0;
      rbyte_d     = '0;
      tmo_d       = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (wr_e) begin
            cmd_d   = din;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          if (wr_e | rd_e) err_proto_d = 1'b1;
          nops_d     = cmd_nops;
          op_idx_d   = 1'b0;
          byte_idx_d = '0;
          case (cmd_nops)
            2'd3:    begin err_cmd_d = 1'b1; state_d = S_IDLE; end
            2'd0:    begin tmo_d = '0; state_d = S_ISSUE; end
            default: state_d = S_OPERAND;
          endcase
        end
        S_OPERAND: begin
          if (rd_e) err_proto_d = 1'b1;
          if (wr_e) begin
            if (!op_idx_q) op_a_d[byte_idx_q*8 +: 8] = din;
            else           op_b_d[byte_idx_q*8 +: 8] = din;
            if (byte_idx_q == LAST_BYTE) begin
              byte_idx_d = '0;
              op_idx_d   = ~op_idx_q;
              if ({1'b0, op_idx_q} == nops_q - 2'd1) begin
                tmo_d   = '0;
                state_d = S_ISSUE;
              end
            end else begin
              byte_idx_d = byte_idx_q + BW'(1);
            end
          end
        end
        S_ISSUE: begin
          if (wr_e | rd_e) err_proto_d = 1'b1;
          if (req_ready) begin
            state_d = S_WAIT;
          end else if (tmo_hit) begin
            err_tmo_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_WAIT: begin
          if (wr_e | rd_e) err_proto_d = 1'b1;
          // A response on the expiry cycle wins over the timeout.
          if (resp_valid) begin
            resp_d  = resp_data;
            len_d   = (resp_len > MAX_LEN) ? MAX_LEN : resp_len;
            rbyte_d = '0;
            state_d = (len_d == '0) ? S_IDLE : S_RESULT;
          end else if (tmo_hit) begin
            err_tmo_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_RESULT: begin
          if (wr_e) err_proto_d = 1'b1;
          if (rd_e) begin
            load_byte = 1'b1;
            hold_d    = 1'b1;
            rbyte_d   = rbyte_q + RW'(1);
            if (LW'(rbyte_q) == len_q - LW'(1)) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // dout tracks the status of the state being entered, so it always agrees
    // with req_valid/resp_ready on the following cycle.
    busy_d = (state_d == S_DECODE) || (state_d == S_OPERAND) ||
             (state_d == S_ISSUE)  || (state_d == S_WAIT);
    rdy_d  = (state_d == S_RESULT);
    if (load_byte)   dout_d = resp_q[rbyte_q*8 +: 8];
    else if (hold_d) dout_d = dout_q;
    else             dout_d = {busy_d, rdy_d, err_cmd_d, err_tmo_d, err_proto_d, 3'b000};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_prev_q   <= 1'b0;
      rd_prev_q   <= 1'b0;
      cmd_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      nops_q      <= '0;
      op_idx_q    <= 1'b0;
      byte_idx_q  <= '0;
      resp_q      <= '0;
      len_q       <= '0;
      rbyte_q     <= '0;
      tmo_q       <= '0;
      err_cmd_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_proto_q <= 1'b0;
      hold_q      <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_prev_q   <= wr;
      rd_prev_q   <= rd;
      cmd_q       <= cmd_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      nops_q      <= nops_d;
      op_idx_q    <= op_idx_d;
      byte_idx_q  <= byte_idx_d;
      resp_q      <= resp_d;
      len_q       <= len_d;
      rbyte_q     <= rbyte_d;
      tmo_q       <= tmo_d;
      err_cmd_q   <= err_cmd_d;
      err_tmo_q   <= err_tmo_d;
      err_proto_q <= err_proto_d;
      hold_q      <= hold_d;
      dout_q      <= dout_d;
    end
  end

  assign dout       = dout_q;
  assign cmd_out    = cmd_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign req_valid  = (state_q == S_ISSUE);
  assign resp_ready = (state_q == S_WAIT);

endmodule

// File: doc/herald_host_bridge.md
Name: herald_host_bridge

Overview:
Parametrised byte-serial host bridge, successor to the Herald top-level command FSM. Collects a command byte and N little-endian operands from an 8-bit strobe bus, then issues one valid/ready request to a downstream accelerator (CORDIC, MAC or future units). It captures a variable-length response and streams it back byte by byte. Adds a readable status byte, sticky error flags, response timeout and a bus-level abort.

Parameters:
OP_BYTES, 3, bytes per operand; operand width W = 8*OP_BYTES
RES_BYTES, 9, maximum response length in bytes
TIMEOUT, 1023, cycles allowed in ISSUE+WAIT before abort; 0 disables the timeout
LW, $clog2(RES_BYTES+1), width of resp_len

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
din  in  8  host write data
wr  in  1  host write strobe (synchronous level; rising edge acts)
rd  in  1  host read strobe (synchronous level; rising edge acts)
dout  out  8  registered host read data / status byte
cmd_out  out  8  latched command byte
cmd_nops  in  2  operand count for cmd_out, from external combinational decode; 3 = illegal
req_valid  out  1  request valid
req_ready  in  1  accelerator accepts request
op_a  out  W  operand A
op_b  out  W  operand B
resp_valid  in  1  response valid
resp_ready  out  1  bridge accepts response
resp_data  in  8*RES_BYTES  response bytes, byte 0 in LSBs
resp_len  in  LW  valid response bytes

Behaviour:
- Reset values: dout=0x00, cmd_out=0, op_a=op_b=0, req_valid=0, resp_ready=0, flags=0, state=IDLE, wr_prev=rd_prev=0.
- Edges: wr_e = wr & ~wr_prev; rd_e = rd & ~rd_prev.
- Abort: wr_e & rd_e in the same cycle, in any state -> IDLE. Clears all error flags and hold. Counters reset. Outstanding response is discarded. Abort overrides every other rule.
- Status byte: {busy, rdy, err_cmd, err_tmo, err_proto, 3'b000}.
  - busy = state in {DECODE, OPERAND, ISSUE, WAIT}.
  - rdy = state is RESULT.
- dout loads the status byte every cycle unless hold=1. hold is set when a data byte is read and cleared on the next wr_e or rd_e, whichever comes first.
- States:
  - IDLE: wr_e -> cmd_out<=din, go to DECODE. rd_e -> no action (status is shown).
  - DECODE (1 cycle):
    - cmd_nops=3 -> set err_cmd, go to IDLE.
    - cmd_nops=0 -> go to ISSUE.
    - otherwise -> go to OPERAND with op_idx=0, byte_idx=0.
  - OPERAND: each wr_e writes din to byte byte_idx of op_a (op_idx 0) or op_b (op_idx 1).
    - The byte index wraps at OP_BYTES and op_idx then increments.
    - After the last byte of operand cmd_nops-1 -> go to ISSUE.
    - rd_e here sets err_proto and is otherwise ignored.
  - ISSUE: req_valid=1 until req_ready is sampled high, then go to WAIT. Operands are stable while req_valid=1.
  - WAIT: resp_ready=1. On resp_valid:
    - Latch resp_data and len = min(resp_len, RES_BYTES).
    - len=0 -> go to IDLE.
    - Otherwise -> go to RESULT with rbyte=0.
  - RESULT: each rd_e sets dout<=byte[rbyte], hold=1, rbyte++.
    - When rbyte reaches len-1 on that read -> go to IDLE, with dout still holding the byte.
    - wr_e here sets err_proto and is ignored.
- Timeout: a counter runs during ISSUE and WAIT and resets on entry to ISSUE. When count==TIMEOUT (TIMEOUT>0), req_valid drops, err_tmo is set and the state goes to IDLE.
- Simultaneous resp_valid and expiry in WAIT: the response wins.
- Simultaneous req_ready and expiry in ISSUE: the handshake completes and the state goes to WAIT. The counter continues.
- rd_e/wr_e in DECODE or ISSUE/WAIT: rd_e sets err_proto; wr_e is ignored and also sets err_proto.
- Error flags are sticky. They clear only on reset or abort.
- Reset mid-operation: immediate return to reset values; any accelerator transaction in flight is abandoned.
- Operand registers keep their last values between commands; unwritten bytes are not cleared.

Test Plan:
- cmd 0x20, cmd_nops=2, bytes 01 02 03 04 05 06 -> op_a=0x030201, op_b=0x060504, req_valid high until req_ready. Response 0xABCDEF, len 3; three rd_e -> dout EF, CD, AB, then status 0x00 after the next strobe.
- cmd_nops=0 (MAC clear), resp len 0 -> status 0x80 during execute, then IDLE with 0x00 and no reads required.
- Normalize, len 9: nine rd_e return bytes 0..8 LSB-first; a tenth rd_e leaves dout at 0x00 status.
- cmd_nops=3 -> dout 0x20 (err_cmd). wr+rd rising together -> 0x00.
- TIMEOUT=16, resp_valid never asserted -> 16 cycles after ISSUE entry, dout=0x10, state IDLE, req_valid=0. Response on the expiry cycle instead -> RESULT with no error.
- rd_e during OPERAND -> err_proto (0x88 while busy). Operand capture is unaffected. Reset mid-WAIT -> all outputs at reset values.
